serial_shifter: RTL and testbench

Transfer engine for the link port, directly downstream of the SB/SC register block at FF01/FF02. On a start request (SC write with bit7=1) it shifts the 8-bit SB value out MSB-first on SO, shifting SI in. It clocks either from its own internal bit clock or from an external SCLK. On completion it hands the received byte back for SB, requests SC bit7 clear, and raises the serial interrupt. It also emits the transmitted byte on a debug capture port, which the test harness uses for console output.

---
 rtl/serial_shifter.sv | 133 +++++++++++++
 tb/tb_serial_shifter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_shifter.sv
// Link-port serial transfer engine: shifts SB out MSB-first on so while sampling si,
// clocked from an internal bit clock or a synchronised external SCLK.
module serial_shifter #(
    parameter int BIT_CYCLES  = 512,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       int_clk,
    input  logic [7:0] sb_in,
    input  logic       si,
    input  logic       ext_sclk,
    output logic       so,
    output logic       sclk_out,
    output logic       busy,
    output logic [7:0] sb_out,
    output logic       sb_update,
    output logic       irq,
    output logic [7:0] tx_byte,
    output logic       tx_valid
);

    localparam int            PW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0] PHASE_HALF = PW'(BIT_CYCLES / 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_INT,
        SHIFT_EXT
    } state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sclk_sync, si_sync_q;
    logic                   sclk_prev;
    logic                   sclk_s, si_sync;
    logic                   sclk_rise, sclk_fall;
    logic [7:0]             shreg;
    logic [2:0]             bit_idx;
    logic [PW-1:0]          phase;
    logic                   shift_edge, out_edge, done;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign si_sync = si_sync_q[SYNC_STAGES-1];

    // Edge history runs in every state so entering SHIFT_EXT never sees a stale edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '1;
            si_sync_q <= '1;
            sclk_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value of its neighbours, as real hardware does.
            sclk_sync[0] <= ext_sclk;
            si_sync_q[0] <= si;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                si_sync_q[i] <= si_sync_q[i-1];
            end
            sclk_prev <= sclk_s;
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_prev;
    assign sclk_fall  = ~sclk_s & sclk_prev;
    assign shift_edge = ((state == SHIFT_INT) && (phase == PHASE_LAST)) ||
                        ((state == SHIFT_EXT) && sclk_rise);
    assign out_edge   = ((state == SHIFT_INT) && (phase == '0)) ||
                        ((state == SHIFT_EXT) && sclk_fall);
    // A restart on the completion edge wins and the completion is dropped.
    assign done       = shift_edge && (bit_idx == 3'd7) && !start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        if (start)     state_next = int_clk ? SHIFT_INT : SHIFT_EXT;
        else if (done) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg     <= 8'h00;
            bit_idx   <= 3'd0;
            phase     <= '0;
            so        <= 1'b1;
            sb_out    <= 8'h00;
            sb_update <= 1'b0;
            irq       <= 1'b0;
            tx_byte   <= 8'h00;
            tx_valid  <= 1'b0;
        end else begin
            tx_valid  <= 1'b0;
            sb_update <= 1'b0;
            irq       <= 1'b0;
            if (start) begin
                shreg    <= sb_in;
                bit_idx  <= 3'd0;
                phase    <= '0;
                so       <= sb_in[7];
                tx_byte  <= sb_in;
                tx_valid <= 1'b1;
            end else if (state == IDLE) begin
                so <= 1'b1;
            end else begin
                if (state == SHIFT_INT)
                    phase <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
                if (out_edge)
                    so <= shreg[7];
                if (shift_edge) begin
                    shreg   <= {shreg[6:0], si_sync};
                    bit_idx <= bit_idx + 3'd1;
                end
                if (done) begin
                    sb_out    <= {shreg[6:0], si_sync};
                    sb_update <= 1'b1;
                    irq       <= 1'b1;
                    so        <= 1'b1;
                end
            end
        end
    end

    assign busy     = (state != IDLE);
    assign sclk_out = ((state == SHIFT_INT) && (phase < PHASE_HALF)) ? 1'b0 : 1'b1;

endmodule

// File: tb/tb_serial_shifter.sv
// Scoreboard bench for serial_shifter: transmitted and received bytes are queued at
// start and compared when tx_valid / sb_update fire.
module tb_serial_shifter;

    localparam int BC = 8;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       int_clk = 1'b0;
    logic [7:0] sb_in = 8'h00;
    logic       si = 1'b1;
    logic       ext_sclk = 1'b1;
    logic       so, sclk_out, busy, sb_update, irq, tx_valid;
    logic [7:0] sb_out, tx_byte;

    int         n_checks = 0;
    int         n_fail = 0;
    int         irq_cnt = 0;
    int         tx_cnt = 0;
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    serial_shifter #(.BIT_CYCLES(BC), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .start(start), .int_clk(int_clk), .sb_in(sb_in),
        .si(si), .ext_sclk(ext_sclk), .so(so), .sclk_out(sclk_out), .busy(busy),
        .sb_out(sb_out), .sb_update(sb_update), .irq(irq), .tx_byte(tx_byte),
        .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_valid) begin
                tx_cnt++;
                if (exp_tx.size() == 0) check("tx_unexpected", 1, 0);
                else                    check("tx_byte", tx_byte, exp_tx.pop_front());
            end
            if (sb_update || irq) check("irq_with_update", irq, sb_update);
            if (irq) irq_cnt++;
            if (sb_update) begin
                if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
                else                    check("sb_out", sb_out, exp_rx.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; start is sampled on the next edge ("edge 0").
    task automatic pulse_start(input logic [7:0] b, input logic ic);
        exp_tx.push_back(b);
        start   = 1'b1;
        sb_in   = b;
        int_clk = ic;
        tick();
        start   = 1'b0;
        int_clk = ~ic;
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        exp_rx.delete();
        exp_tx.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        int         irq0, tx0, lat;
        bit         found;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_so", so, 1);
        check("rst_sclk", sclk_out, 1);
        check("rst_sb_out", sb_out, 8'h00);
        check("rst_upd_irq", {sb_update, irq, tx_valid}, 3'b000);
        check("rst_tx_byte", tx_byte, 8'h00);
        reset = 1'b0;
        tick();

        // Internal clock, si held high, A5 out
        pat = 8'hA5;
        si  = 1'b1;
        exp_rx.push_back(8'hFF);
        irq0 = irq_cnt;
        pulse_start(pat, 1'b1);
        check("int_busy_start", busy, 1);
        for (int k = 0; k < 64; k++) begin
            if (k > 0) tick();
            check("int_sclk", sclk_out, ((k % BC) >= BC / 2) ? 1 : 0);
            if ((k % BC) == BC / 2) check("int_so", so, pat[7 - k / BC]);
        end
        check("int_busy_63", busy, 1);
        check("int_upd_63", sb_update, 0);
        tick();
        check("int_upd_64", sb_update, 1);
        check("int_busy_64", busy, 0);
        check("int_so_idle", so, 1);
        tick();
        check("int_upd_65", sb_update, 0);
        check("int_irq_once", irq_cnt - irq0, 1);

        // Internal clock, 3C received on si
        pat = 8'h3C;
        exp_rx.push_back(pat);
        irq0 = irq_cnt;
        pulse_start(8'h00, 1'b1);
        for (int k = 0; k < 64; k++) begin
            if (k > 0) tick();
            if ((k % BC) == 0) si = pat[7 - k / BC];
        end
        tick();
        check("rx3c_upd", sb_update, 1);
        tick();
        check("rx3c_irq_once", irq_cnt - irq0, 1);
        si = 1'b1;

        // External clock, 8 pulses, si low
        pat = 8'h81;
        si  = 1'b0;
        exp_rx.push_back(8'h00);
        pulse_start(pat, 1'b0);
        check("ext_busy", busy, 1);
        check("ext_sclk_static", sclk_out, 1);
        for (int p = 0; p < 8; p++) begin
            ext_sclk = 1'b0;
            repeat (10) tick();
            check("ext_so", so, pat[7 - p]);
            ext_sclk = 1'b1;
            if (p < 7) repeat (10) tick();
        end
        found = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 10 && !found; n++) begin
            tick();
            if (sb_update) begin
                found = 1'b1;
                lat   = n;
            end
        end
        check("ext_done_seen", found, 1);
        check("ext_latency", lat, SS + 1);
        tick();

        // External clock, only 7 pulses: must stay busy
        irq0 = irq_cnt;
        pulse_start(8'h81, 1'b0);
        for (int p = 0; p < 7; p++) begin
            ext_sclk = 1'b0;
            repeat (10) tick();
            ext_sclk = 1'b1;
            repeat (10) tick();
        end
        repeat (30) tick();
        check("ext7_busy", busy, 1);
        check("ext7_no_irq", irq_cnt - irq0, 0);
        apply_reset();
        si = 1'b1;
        tick();

        // Restart at cycle 30 of an internal transfer
        irq0 = irq_cnt;
        tx0  = tx_cnt;
        exp_rx.push_back(8'hFF);
        pulse_start(8'hA5, 1'b1);
        repeat (29) tick();
        void'(exp_rx.pop_back());
        exp_rx.push_back(8'hFF);
        pulse_start(8'h55, 1'b1);
        repeat (63) tick();
        check("abort_no_irq", irq_cnt - irq0, 0);
        check("abort_busy", busy, 1);
        tick();
        check("abort_upd_94", sb_update, 1);
        tick();
        check("abort_irq_once", irq_cnt - irq0, 1);
        check("abort_tx_twice", tx_cnt - tx0, 2);

        // Asynchronous reset at cycle 20
        irq0 = irq_cnt;
        exp_rx.push_back(8'hFF);
        pulse_start(8'hA5, 1'b1);
        repeat (19) tick();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_so", so, 1);
        check("mid_rst_sclk", sclk_out, 1);
        check("mid_rst_sb_out", sb_out, 8'h00);
        exp_rx.delete();
        tick();
        tick();
        reset = 1'b0;
        repeat (80) tick();
        check("mid_rst_no_irq", irq_cnt - irq0, 0);
        exp_rx.push_back(8'hFF);
        pulse_start(8'h3C, 1'b1);
        repeat (63) tick();
        tick();
        check("post_rst_upd", sb_update, 1);
        check("post_rst_sb_out", sb_out, 8'hFF);
        tick();

        // Start on the completion edge
        irq0 = irq_cnt;
        exp_rx.push_back(8'hFF);
        pulse_start(8'hA5, 1'b1);
        repeat (63) tick();
        void'(exp_rx.pop_back());
        exp_rx.push_back(8'hFF);
        pulse_start(8'h5A, 1'b1);
        check("coll_no_upd", sb_update, 0);
        check("coll_busy", busy, 1);
        repeat (63) tick();
        check("coll_no_irq_yet", irq_cnt - irq0, 0);
        tick();
        check("coll_upd", sb_update, 1);
        tick();
        check("coll_irq_once", irq_cnt - irq0, 1);

        repeat (5) tick();
        check("rx_queue_empty", exp_rx.size(), 0);
        check("tx_queue_empty", exp_tx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
